// File: rtl/ask_frame_ctrl.sv
// Frame sequencer feeding the 2ASK modulator: preamble, MSB-first payload from a
// one-byte holding register, zero-level guard tail, with done/underrun/abort handling.
module ask_frame_ctrl #(
    parameter int unsigned SYM_DIV   = 16,
    parameter logic [7:0]  PRE_BYTE  = 8'hAA,
    parameter int unsigned PRE_BYTES = 2,
    parameter int unsigned GUARD     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] len,
    input  logic       abort,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       sym_bit,
    output logic       sym_strobe,
    output logic       busy,
    output logic       done,
    output logic       err_underrun
);

    localparam int unsigned   CW         = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;
    localparam logic [CW-1:0] SYM_LAST   = CW'(SYM_DIV - 1);
    localparam logic [7:0]    PRE_LAST   = 8'(PRE_BYTES - 1);
    localparam logic [7:0]    GUARD_LAST = (GUARD > 0) ? 8'(GUARD - 1) : 8'd0;
    localparam bit            HAS_GUARD  = (GUARD > 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_PAY  = 2'd2,
        ST_TAIL = 2'd3
    } state_t;

    state_t        state_r, state_n;
    logic [CW-1:0] sym_cnt_r, sym_cnt_n;
    logic [2:0]    bit_cnt_r, bit_cnt_n;
    logic [7:0]    byte_cnt_r, byte_cnt_n;
    logic [7:0]    tail_cnt_r, tail_cnt_n;
    logic [7:0]    fetched_r, fetched_n;
    logic [7:0]    len_r, len_n;
    logic [7:0]    shift_r, shift_n;
    logic [7:0]    hold_data_r, hold_data_n;
    logic          hold_valid_r, hold_valid_n;

    logic tx_ready_r, sym_bit_r, sym_strobe_r, busy_r, done_r, err_underrun_r;
    logic xfer_s, pay_load_s, data_end_s, finish_s, under_s;
    logic tx_ready_n, sym_bit_n, sym_strobe_n, busy_n;

    assign tx_ready     = tx_ready_r;
    assign sym_bit      = sym_bit_r;
    assign sym_strobe   = sym_strobe_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign err_underrun = err_underrun_r;

    // Next-state, counters, holding register and next output values
    always_comb begin
        state_n      = state_r;
        sym_cnt_n    = sym_cnt_r;
        bit_cnt_n    = bit_cnt_r;
        byte_cnt_n   = byte_cnt_r;
        tail_cnt_n   = tail_cnt_r;
        fetched_n    = fetched_r;
        len_n        = len_r;
        shift_n      = shift_r;
        hold_data_n  = hold_data_r;
        hold_valid_n = hold_valid_r;
        pay_load_s   = 1'b0;
        data_end_s   = 1'b0;
        finish_s     = 1'b0;
        under_s      = 1'b0;
        xfer_s       = tx_valid && tx_ready_r;

        if (state_r == ST_IDLE) begin
            if (start) begin
                state_n      = ST_PRE;
                len_n        = len;
                shift_n      = PRE_BYTE;
                sym_cnt_n    = '0;
                bit_cnt_n    = 3'd0;
                byte_cnt_n   = 8'd0;
                tail_cnt_n   = 8'd0;
                fetched_n    = 8'd0;
                hold_valid_n = 1'b0;
            end else begin
                state_n = ST_IDLE;
            end
        end else if (abort) begin
            state_n      = ST_IDLE;
            hold_valid_n = 1'b0;
        end else begin
            if (xfer_s) begin
                hold_data_n  = tx_data;
                hold_valid_n = 1'b1;
                fetched_n    = fetched_r + 8'd1;
            end else begin
                hold_valid_n = hold_valid_r;
            end

            if (sym_cnt_r == SYM_LAST) begin
                sym_cnt_n = '0;
                if (state_r == ST_TAIL) begin
                    if (tail_cnt_r == GUARD_LAST) begin
                        finish_s = 1'b1;
                    end else begin
                        tail_cnt_n = tail_cnt_r + 8'd1;
                    end
                end else if (bit_cnt_r != 3'd7) begin
                    shift_n   = {shift_r[6:0], 1'b0};
                    bit_cnt_n = bit_cnt_r + 3'd1;
                end else begin
                    bit_cnt_n = 3'd0;
                    if (state_r == ST_PRE) begin
                        if (byte_cnt_r == PRE_LAST) begin
                            byte_cnt_n = 8'd0;
                            if (len_r != 8'd0) begin
                                pay_load_s = 1'b1;
                            end else begin
                                data_end_s = 1'b1;
                            end
                        end else begin
                            shift_n    = PRE_BYTE;
                            byte_cnt_n = byte_cnt_r + 8'd1;
                        end
                    end else begin
                        if ((byte_cnt_r + 8'd1) == len_r) begin
                            data_end_s = 1'b1;
                        end else begin
                            byte_cnt_n = byte_cnt_r + 8'd1;
                            pay_load_s = 1'b1;
                        end
                    end
                end
            end else begin
                sym_cnt_n = sym_cnt_r + CW'(1);
            end

            // A byte arriving in the boundary cycle itself bypasses the holding register
            if (pay_load_s) begin
                state_n = ST_PAY;
                if (hold_valid_r) begin
                    shift_n      = hold_data_r;
                    hold_valid_n = 1'b0;
                end else if (xfer_s) begin
                    shift_n      = tx_data;
                    hold_valid_n = 1'b0;
                end else begin
                    state_n      = ST_IDLE;
                    under_s      = 1'b1;
                    hold_valid_n = 1'b0;
                end
            end else begin
                under_s = 1'b0;
            end

            if (data_end_s) begin
                if (HAS_GUARD) begin
                    state_n    = ST_TAIL;
                    tail_cnt_n = 8'd0;
                end else begin
                    finish_s = 1'b1;
                end
            end else begin
                finish_s = finish_s;
            end

            if (finish_s) begin
                state_n = ST_IDLE;
            end else begin
                state_n = state_n;
            end
        end

        busy_n       = (state_n != ST_IDLE);
        sym_bit_n    = ((state_n == ST_PRE) || (state_n == ST_PAY)) ? shift_n[7] : 1'b0;
        sym_strobe_n = busy_n && (sym_cnt_n == '0);
        tx_ready_n   = busy_n && !hold_valid_n && (fetched_n < len_n);
    end

    // Frame state, counters and holding register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            sym_cnt_r    <= '0;
            bit_cnt_r    <= 3'd0;
            byte_cnt_r   <= 8'd0;
            tail_cnt_r   <= 8'd0;
            fetched_r    <= 8'd0;
            len_r        <= 8'd0;
            shift_r      <= 8'd0;
            hold_data_r  <= 8'd0;
            hold_valid_r <= 1'b0;
        end else begin
            state_r      <= state_n;
            sym_cnt_r    <= sym_cnt_n;
            bit_cnt_r    <= bit_cnt_n;
            byte_cnt_r   <= byte_cnt_n;
            tail_cnt_r   <= tail_cnt_n;
            fetched_r    <= fetched_n;
            len_r        <= len_n;
            shift_r      <= shift_n;
            hold_data_r  <= hold_data_n;
            hold_valid_r <= hold_valid_n;
        end
    end

    // Output flops, loaded from next-state values so outputs line up with the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_ready_r     <= 1'b0;
            sym_bit_r      <= 1'b0;
            sym_strobe_r   <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            err_underrun_r <= 1'b0;
        end else begin
            tx_ready_r     <= tx_ready_n;
            sym_bit_r      <= sym_bit_n;
            sym_strobe_r   <= sym_strobe_n;
            busy_r         <= busy_n;
            done_r         <= finish_s;
            err_underrun_r <= under_s;
        end
    end

endmodule

// File: doc/ask_frame_ctrl.md
# ask_frame_ctrl

Frame sequencer that sits in front of the 2ASK modulator and drives its baseband bit. It accepts payload bytes over a valid/ready stream and emits them MSB-first as symbols at a programmable rate. Each frame is wrapped with a fixed preamble and a zero-level guard tail, and the block signals completion, underrun and abort. Its `sym_bit` output connects directly to the modulator's baseband input.

## Interface
- `SYM_DIV`, 16: clock cycles per symbol; legal range is 2..65535.
- `PRE_BYTE`, 8'hAA: preamble byte value, sent MSB-first.
- `PRE_BYTES`, 2: number of preamble bytes; legal range is 1..15.
- `GUARD`, 4: number of trailing zero symbols; legal range is 0..255.
- `clk` in 1: the single system clock.
- `rst_n` in 1: asynchronous reset, active-low.
- `start` in 1: frame request; sampled only in IDLE.
- `len` in 8: payload byte count, sampled with `start`; 0 is legal and sends preamble plus tail only.
- `abort` in 1: synchronous abort; honoured in any non-IDLE state.
- `tx_data` in 8: payload byte.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: holding register can accept a byte.
- `sym_bit` out 1: baseband bit to the modulator.
- `sym_strobe` out 1: one-cycle pulse on the first cycle of each symbol.
- `busy` out 1: high while a frame is in progress.
- `done` out 1: one-cycle pulse when a frame completes normally.
- `err_underrun` out 1: one-cycle pulse when the frame is aborted because no payload byte was available.

## Operation
- States:
  - IDLE
  - PRE: preamble symbols
  - PAY: payload symbols
  - TAIL: guard symbols
- Frame start: in IDLE, `start`=1 latches `len` and moves to PRE. Shift register loads `PRE_BYTE`; bit counter and symbol counter clear.
- Symbol timer: the counter runs 0..`SYM_DIV`-1 and wraps. At the wrap, the shift register advances one bit and the bit counter increments.
- Byte boundaries: every 8 symbols the shift register reloads:
  - In PRE, it reloads `PRE_BYTE` until `PRE_BYTES` bytes have been sent.
  - After the preamble, it goes to PAY (if `len`>0) or to TAIL.
  - In PAY, it reloads from the holding register until `len` bytes have been sent, then goes to TAIL.
- TAIL: `sym_bit`=0 for `GUARD` symbols. If `GUARD`=0, TAIL is skipped and the frame goes straight to completion.
- Completion: return to IDLE and pulse `done`.
- Holding register (1 byte):
  - `tx_ready` = busy AND holding empty AND bytes fetched < `len`. Prefetch is allowed during PRE.
  - A transfer occurs when `tx_valid` & `tx_ready`.
- Underrun: at a PAY load boundary with the holding register empty and no transfer in that cycle:
  - pulse `err_underrun`;
  - go to IDLE; `sym_bit`=0;
  - no `done` pulse.
- Bypass: a transfer in the load-boundary cycle itself loads directly into the shift register. This is not an underrun.
- Abort: `abort`=1 in any non-IDLE state gives IDLE on the next edge. `sym_bit`=0, holding register cleared, no `done`, no `err_underrun`. If `abort` and `start` are both high in IDLE, `start` wins.
- In IDLE: `sym_bit`=0, `tx_ready`=0, `start` is ignored while busy.
- Widths:
  - symbol counter: `$clog2(SYM_DIV)` bits
  - byte counters: 8 bits, compared against the latched `len`
  - tail counter: 8 bits
  - no wrap-around is possible within legal parameters

## Timing
- Reset (async, `rst_n`=0): state IDLE.
  - All outputs 0: `sym_bit`, `sym_strobe`, `busy`, `done`, `err_underrun`, `tx_ready`.
  - Holding register empty, all counters 0.
- Reset asserted mid-frame: immediate IDLE; no `done` or `err_underrun` pulse.
- Edge N samples `start`. From cycle N+1:
  - `busy`=1;
  - `sym_bit` = `PRE_BYTE`[7];
  - `sym_strobe`=1.
- Each symbol holds for exactly `SYM_DIV` cycles. `sym_strobe` is high only on count 0.
- Frame length: `busy` stays high for exactly (8·(`PRE_BYTES`+`len`)+`GUARD`)·`SYM_DIV` cycles.
- On the cycle after the last one:
  - `busy`=0 and `done`=1 in that same cycle;
  - `sym_bit`=0.
- Underrun/abort: `busy` drops on the cycle after the offending edge. `err_underrun` is high in that same cycle (underrun only).
- All outputs are registered. There is no combinational path from `tx_valid` to `tx_ready`.

## Test plan
- Basic frame: `SYM_DIV`=4, `PRE_BYTES`=1, `GUARD`=2, `len`=1, byte 8'h5A supplied early.
  - `sym_bit` sequence is 10101010 01011010 00, each bit held 4 cycles.
  - `busy` lasts 72 cycles; `done` pulses once.
- Zero length: `len`=0.
  - Only preamble plus tail is sent (`PRE_BYTES`·8+`GUARD` symbols).
  - `tx_ready` never asserts; `done` pulses once.
- Underrun: `len`=2, first byte supplied, second byte withheld.
  - `err_underrun` pulses at the end of byte 1's last symbol; `busy`=0 next cycle.
  - No `done`.
- Bypass: the second byte's `tx_valid` is first asserted exactly in the load-boundary cycle.
  - No underrun; the byte is transmitted correctly with no gap.
- Abort and reset: `abort` mid-PAY gives IDLE on the next cycle with `sym_bit`=0 and no pulses. A new `start` then runs a clean frame. Repeating with `rst_n` pulsed low mid-TAIL gives all outputs at 0 immediately.
- Back-to-back frames: `start` held high while busy is ignored. `start` re-asserted in the `done` cycle begins a new frame the next cycle with `sym_strobe`=1.
